// File: rtl/tangram_piece_render_if.sv
// Pixel/control bundle between the VGA timing generator, the piece controls and one
// tangram_piece_render instance.
//
// Parameters: CW (coordinate width), SW (size width); must match the renderer.
// Signals:
//   hc, vc      current pixel column/row            (master -> slave)
//   vidon       visible-area flag aligned with hc/vc (master -> slave)
//   frame_tick  1-cycle pulse at start of v-blank    (master -> slave)
//   shape, size piece type and size s                (master -> slave)
//   px, py      home anchor                          (master -> slave)
//   select      piece selected                       (master -> slave)
//   rotate      rotate button level                  (master -> slave)
//   move        [0] up [1] down [2] left [3] right   (master -> slave)
//   color       pixel mask, 2-cycle latency          (slave -> master)
//   rot, ax, ay committed rotation and anchor        (slave -> master)
// The renderer uses the slave modport; the driver side uses master.
interface tangram_piece_render_if #(
   parameter int unsigned CW = 11,
   parameter int unsigned SW = 10
) ();
   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic          vidon;
   logic          frame_tick;
   logic [1:0]    shape;
   logic [SW-1:0] size;
   logic [CW-1:0] px;
   logic [CW-1:0] py;
   logic          select;
   logic          rotate;
   logic [3:0]    move;
   logic          color;
   logic [1:0]    rot;
   logic [CW-1:0] ax;
   logic [CW-1:0] ay;

   modport master (
      output hc, vc, vidon, frame_tick, shape, size, px, py, select, rotate, move,
      input  color, rot, ax, ay
   );

   modport slave (
      input  hc, vc, vidon, frame_tick, shape, size, px, py, select, rotate, move,
      output color, rot, ax, ay
   );
endinterface

// File: rtl/tangram_piece_render.sv
// Single tangram piece renderer (large/small triangle, parallelogram, diamond).
// Button edges while selected are latched as pending rotate/move requests and committed
// once per frame on frame_tick; the anchor is clamped to the visible screen. A 2-stage
// pipeline turns the current pixel (hc, vc) into a 1-bit colour mask aligned with vidon.
//
// Ports:
//   clk_40m  pixel clock
//   rst_n    asynchronous active-low reset
//   bus      tangram_piece_render_if.slave (pixel position, controls, mask, rot/ax/ay)
//
// Optional feature: define HOLD_REPEAT_EN to auto-repeat a held move after REPEAT_DLY
// frame ticks, then every REPEAT_RATE ticks. Without it, one step per rising edge.
module tangram_piece_render #(
   parameter int unsigned CW          = 11,
   parameter int unsigned SW          = 10,
   parameter int unsigned STEP        = 5,
   parameter int unsigned H_ACTIVE    = 800,
   parameter int unsigned V_ACTIVE    = 600,
   parameter int unsigned REPEAT_DLY  = 8,
   parameter int unsigned REPEAT_RATE = 2
) (
   input logic                    clk_40m,
   input logic                    rst_n,
   tangram_piece_render_if.slave  bus
);
   localparam int unsigned AW = CW + 2;  // signed anchor/delta width
   localparam int unsigned BW = CW + 3;  // headroom for dx+dy, dy-dx and 2s

   localparam logic signed [AW-1:0] StepS = AW'(STEP);
   localparam logic signed [AW-1:0] HMax  = AW'(H_ACTIVE - 1);
   localparam logic signed [AW-1:0] VMax  = AW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

   // Highest-priority set bit: up > down > left > right.
   function automatic dir_e prio_dir(input logic [3:0] m);
      if (m[0])      return DirUp;
      else if (m[1]) return DirDown;
      else if (m[2]) return DirLeft;
      else           return DirRight;
   endfunction

   function automatic logic is_neg(input logic signed [BW-1:0] v);
      return v[BW-1];
   endfunction

   function automatic logic is_pos(input logic signed [BW-1:0] v);
      return !v[BW-1] && (v != '0);
   endfunction

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   logic [3:0]           move_q, move_d;
   logic                 rotate_q, rotate_d;
   logic                 select_q, select_d;
   logic                 pend_rot_q, pend_rot_d;
   logic                 pend_dir_vld_q, pend_dir_vld_d;
   dir_e                 pend_dir_q, pend_dir_d;
   logic signed [AW-1:0] cx_q, cx_d;
   logic signed [AW-1:0] cy_q, cy_d;
   logic [1:0]           rot_q, rot_d;

   logic [3:0]           move_rise;
   logic                 rot_rise;
   logic                 new_dir_vld;
   dir_e                 new_dir;
   logic                 eff_dir_vld;
   dir_e                 eff_dir;
   logic                 eff_rot;
   logic signed [AW-1:0] ax_full, ay_full;
   logic signed [AW-1:0] step_x, step_y;
   logic signed [AW-1:0] nx, ny, nx_cl, ny_cl;
   logic                 rep_fire;
   dir_e                 rep_dir;

   assign ax_full = $signed({2'b00, bus.px}) + cx_q;
   assign ay_full = $signed({2'b00, bus.py}) + cy_q;

`ifdef HOLD_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_DLY + 1) + 1;
   // After a repeat the counter restarts so it hits REPEAT_DLY again REPEAT_RATE ticks later.
   localparam logic [RW-1:0] RepDly    = RW'(REPEAT_DLY);
   localparam logic [RW-1:0] RepReload = RW'(REPEAT_DLY - REPEAT_RATE + 1);

   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   dir_e          rep_dir_q, rep_dir_d;
   logic          held;

   always_comb begin
      held      = bus.select & (|bus.move);
      rep_dir   = prio_dir(bus.move);
      rep_dir_d = rep_dir;
      rep_fire  = held && bus.frame_tick && (rep_dir == rep_dir_q) && (rep_cnt_q == RepDly);
      rep_cnt_d = rep_cnt_q;
      if (!held || (rep_dir != rep_dir_q)) begin
         rep_cnt_d = '0;
      end else if (bus.frame_tick) begin
         rep_cnt_d = rep_fire ? RepReload : rep_cnt_q + RW'(1);
      end
   end

   always_ff @(posedge clk_40m or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
         rep_dir_q <= DirUp;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_dir_q <= rep_dir_d;
      end
   end
`else
   assign rep_fire = 1'b0;
   assign rep_dir  = DirUp;
`endif

   // Edge detection and pending requests
   always_comb begin
      move_d   = bus.move;
      rotate_d = bus.rotate;
      select_d = bus.select;

      move_rise   = bus.move & ~move_q & {4{bus.select}};
      rot_rise    = bus.rotate & ~rotate_q & bus.select;
      new_dir_vld = |move_rise;
      new_dir     = prio_dir(move_rise);

      // A fresh edge in the tick cycle wins over an older pending one.
      eff_dir_vld = bus.select & (new_dir_vld | pend_dir_vld_q | rep_fire);
      if (new_dir_vld)         eff_dir = new_dir;
      else if (pend_dir_vld_q) eff_dir = pend_dir_q;
      else                     eff_dir = rep_dir;
      eff_rot = bus.select & (rot_rise | pend_rot_q);

      pend_rot_d     = pend_rot_q;
      pend_dir_vld_d = pend_dir_vld_q;
      pend_dir_d     = pend_dir_q;
      if (bus.frame_tick || (select_q && !bus.select)) begin
         pend_rot_d     = 1'b0;
         pend_dir_vld_d = 1'b0;
      end else begin
         if (new_dir_vld) begin
            pend_dir_vld_d = 1'b1;
            pend_dir_d     = new_dir;
         end
         if (rot_rise) pend_rot_d = 1'b1;
      end
   end

   // Commit with clamping; the anchor is re-clamped on every tick.
   always_comb begin
      step_x = '0;
      step_y = '0;
      if (eff_dir_vld) begin
         unique case (eff_dir)
            DirUp:    step_y = -StepS;
            DirDown:  step_y = StepS;
            DirLeft:  step_x = -StepS;
            DirRight: step_x = StepS;
            default:  ;
         endcase
      end
      nx = ax_full + step_x;
      ny = ay_full + step_y;

      if (nx[AW-1])      nx_cl = '0;
      else if (nx > HMax) nx_cl = HMax;
      else               nx_cl = nx;
      if (ny[AW-1])      ny_cl = '0;
      else if (ny > VMax) ny_cl = VMax;
      else               ny_cl = ny;

      cx_d  = cx_q;
      cy_d  = cy_q;
      rot_d = rot_q;
      if (bus.frame_tick) begin
         cx_d = nx_cl - $signed({2'b00, bus.px});
         cy_d = ny_cl - $signed({2'b00, bus.py});
         if (eff_rot) rot_d = rot_q + 2'd1;
      end
   end

   // ------------------------------------------------------------------
   // Render pipeline
   // ------------------------------------------------------------------
   logic signed [AW-1:0] dx_q1, dx_d1;
   logic signed [AW-1:0] dy_q1, dy_d1;
   logic [1:0]           shape_q1;
   logic [1:0]           rot_q1;
   logic [SW-1:0]        s_q1;
   logic                 vid_q1;
   logic                 color_q, color_d;

   always_comb begin
      dx_d1 = $signed({2'b00, bus.hc}) - ax_full;
      dy_d1 = $signed({2'b00, bus.vc}) - ay_full;
   end

   logic signed [BW-1:0] dxb, dyb, sb, s2b, nsb, ns2b, sum, dif;
   logic                 hit;

   always_comb begin
      dxb  = {dx_q1[AW-1], dx_q1};
      dyb  = {dy_q1[AW-1], dy_q1};
      sb   = $signed({{(BW - SW){1'b0}}, s_q1});
      s2b  = sb <<< 1;
      nsb  = -sb;
      ns2b = -s2b;
      sum  = dxb + dyb;
      dif  = dyb - dxb;
      hit  = 1'b0;
      unique case (shape_q1)
         2'b00: begin
            unique case (rot_q1)
               2'd0: hit = is_neg(dyb) && (sum > nsb) && (dif > nsb);
               2'd1: hit = is_pos(dxb) && (sum < sb)  && (dif > nsb);
               2'd2: hit = is_pos(dyb) && (sum < sb)  && (dif < sb);
               default: hit = is_neg(dxb) && (sum > nsb) && (dif < sb);
            endcase
         end
         2'b01: begin
            unique case (rot_q1)
               2'd0: hit = is_neg(dxb) && is_pos(dyb) && (dif < sb);
               2'd1: hit = is_neg(dxb) && is_neg(dyb) && (sum > nsb);
               2'd2: hit = is_pos(dxb) && is_neg(dyb) && (dif > nsb);
               default: hit = is_pos(dxb) && is_pos(dyb) && (sum < sb);
            endcase
         end
         2'b10: begin
            unique case (rot_q1)
               2'd0: hit = (dxb > nsb) && is_neg(dxb) && (dif > ns2b) && is_neg(dif);
               2'd1: hit = (dyb > nsb) && is_neg(dyb) && is_pos(sum) && (sum < s2b);
               2'd2: hit = is_pos(dxb) && (dxb < sb) && is_pos(dif) && (dif < s2b);
               default: hit = is_pos(dyb) && (dyb < sb) && (sum > ns2b) && is_neg(sum);
            endcase
         end
         default: hit = (dif < sb) && (dif > nsb) && (sum < sb) && (sum > nsb);
      endcase
      color_d = hit & vid_q1;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_40m or negedge rst_n) begin
      if (!rst_n) begin
         move_q         <= '0;
         rotate_q       <= 1'b0;
         select_q       <= 1'b0;
         pend_rot_q     <= 1'b0;
         pend_dir_vld_q <= 1'b0;
         pend_dir_q     <= DirUp;
         cx_q           <= '0;
         cy_q           <= '0;
         rot_q          <= '0;
         dx_q1          <= '0;
         dy_q1          <= '0;
         shape_q1       <= '0;
         rot_q1         <= '0;
         s_q1           <= '0;
         vid_q1         <= 1'b0;
         color_q        <= 1'b0;
      end else begin
         move_q         <= move_d;
         rotate_q       <= rotate_d;
         select_q       <= select_d;
         pend_rot_q     <= pend_rot_d;
         pend_dir_vld_q <= pend_dir_vld_d;
         pend_dir_q     <= pend_dir_d;
         cx_q           <= cx_d;
         cy_q           <= cy_d;
         rot_q          <= rot_d;
         dx_q1          <= dx_d1;
         dy_q1          <= dy_d1;
         shape_q1       <= bus.shape;
         rot_q1         <= rot_q;
         s_q1           <= bus.size;
         vid_q1         <= bus.vidon;
         color_q        <= color_d;
      end
   end

   assign bus.color = color_q;
   assign bus.rot   = rot_q;
   assign bus.ax    = ax_full[CW-1:0];
   assign bus.ay    = ay_full[CW-1:0];

endmodule
